// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks.
// Gray/binary helpers work on a wide word; callers zero-extend and truncate.
package fifo_pkg;

  localparam int ADDR_SIZE_DEF = 4;
  localparam int PTR_MAX = 32;

  typedef logic [PTR_MAX-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return (b >> 1) ^ b;
  endfunction

  // Leading zeros from zero-extension leave the low bits unaffected.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = '0;
    for (int i = 0; i < PTR_MAX; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a Gray-coded pointer crossing into clk.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full flags and conservative level for the async FIFO.
// Freed slots are credited only once the read pointer emerges from the synchroniser.
import fifo_pkg::*;

module fifo_wptr_full #(
  parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req,
  input  logic [ADDR_SIZE:0]   rd_ptr_gray,
  output logic                 wr_en,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic                 wr_full,
  output logic                 wr_almost_full,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic                 wr_overflow
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_reg, wbin_next;
  logic [PW-1:0] wgray_reg, wgray_next;
  logic [PW-1:0] level_reg, level_next;
  logic [PW-1:0] rq2, rbin_s, full_cmp;
  logic          full_reg, full_next;
  logic          afull_reg, afull_next;
  logic          ovf_reg, ovf_next;

  sync_2ff #(.WIDTH(PW)) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rd_ptr_gray),
    .q   (rq2)
  );

  // Judged against the registered flag, so a same-cycle read never rescues a write.
  assign wr_en = wr_req & ~full_reg & ~rst;

  always_comb begin
    wbin_next  = wbin_reg + PW'(wr_en);
    wgray_next = PW'(bin2gray(ptr_max_t'(wbin_next)));
    rbin_s     = PW'(gray2bin(ptr_max_t'(rq2)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_cmp   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    full_next  = (wgray_next == full_cmp);
    level_next = wbin_next - rbin_s;
    afull_next = (level_next >= AFULL_LVL);
    ovf_next   = ovf_reg | (wr_req & full_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_reg  <= '0;
      wgray_reg <= '0;
      level_reg <= '0;
      full_reg  <= 1'b0;
      afull_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      wbin_reg  <= wbin_next;
      wgray_reg <= wgray_next;
      level_reg <= level_next;
      full_reg  <= full_next;
      afull_reg <= afull_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign wr_addr        = wbin_reg[ADDR_SIZE-1:0];
  assign wr_full        = full_reg;
  assign wr_almost_full = afull_reg;
  assign wr_level       = level_reg;
  assign wr_ptr_gray    = wgray_reg;
  assign wr_overflow    = ovf_reg;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: occupancy model over write/read counts with a
// two-edge credit lag for reads, directed phases followed by randomized traffic.
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_req = 1'b0;
  logic [4:0] rd_ptr_gray = '0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic       wr_full;
  logic       wr_almost_full;
  logic [4:0] wr_level;
  logic [4:0] wr_ptr_gray;
  logic       wr_overflow;

  fifo_wptr_full #(.ADDR_SIZE(4), .AFULL_THRESH(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_req         (wr_req),
    .rd_ptr_gray    (rd_ptr_gray),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_ptr_gray    (wr_ptr_gray),
    .wr_overflow    (wr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit en;
    int addr_pre;
    int addr;
    int gray;
    int level;
    bit full;
    bit af;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  bit   drv_done = 0;

  // Model: total accepted writes and read counts seen one and two edges ago.
  int m_writes = 0;
  bit m_full = 0;
  bit m_ovf = 0;
  int rd_lag1 = 0;
  int rd_lag2 = 0;

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  task automatic step(input bit r, input bit req, input int rd);
    exp_t e;
    int   lvl;
    @(negedge clk);
    rst = r;
    wr_req = req;
    rd_ptr_gray = gray5(rd);
    e.rst = r;
    e.addr_pre = m_writes % 16;
    if (r) begin
      m_writes = 0;
      m_full = 0;
      m_ovf = 0;
      rd_lag1 = 0;
      rd_lag2 = 0;
      e.en = 0;
      lvl = 0;
    end else begin
      e.en = req && !m_full;
      if (req && m_full) m_ovf = 1;
      m_writes += int'(e.en);
      lvl = (m_writes - rd_lag2) & 31;
      m_full = (lvl == 16);
      rd_lag2 = rd_lag1;
      rd_lag1 = rd;
    end
    e.addr  = m_writes % 16;
    e.gray  = int'(gray5(m_writes));
    e.level = lvl;
    e.full  = m_full;
    e.af    = (lvl >= 12);
    e.ovf   = m_ovf;
    exp_q.push_back(e);
  endtask

  // Stimulus
  initial begin
    int rdc;
    step(1, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(0, 1, 1);
    step(1, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, (m_writes > 4) ? m_writes - 4 : 0);
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    rdc = 0;
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom_range(0, 63) == 0);
      if (r) rdc = 0;
      else if (rdc < m_writes && $urandom_range(0, 1) == 1) rdc++;
      step(r, $urandom_range(0, 3) != 0, rdc);
    end
    @(negedge clk);
    wr_req = 0;
    drv_done = 1;
  end

  // Monitor: combinational outputs before the edge, registered outputs after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("wr_en", 32'(wr_en), 32'(e.en));
        chk("wr_addr_pre", 32'(wr_addr), e.addr_pre);
        @(posedge clk);
        #1;
        chk("wr_addr", 32'(wr_addr), e.addr);
        chk("wr_ptr_gray", 32'(wr_ptr_gray), e.gray);
        chk("wr_level", 32'(wr_level), e.level);
        chk("wr_full", 32'(wr_full), 32'(e.full));
        chk("wr_almost_full", 32'(wr_almost_full), 32'(e.af));
        chk("wr_overflow", 32'(wr_overflow), 32'(e.ovf));
        $display("txn rst=%0b en=%0b addr=%0d gray=%0h lvl=%0d full=%0b af=%0b ovf=%0b",
                 e.rst, wr_en, wr_addr, wr_ptr_gray, wr_level, wr_full, wr_almost_full,
                 wr_overflow);
        void'(exp_q.pop_front());
      end else if (drv_done) begin
        break;
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
